// File: rtl/execute_if.sv
// Execute-stage bus bundle: decoder instruction port, memory port and
// writeback port of the 8-bit core.
//   slave  : the execute stage (accepts instructions, drives mem_*/wb_*).
//   master : the surrounding core (decoder, memory, writeback).
interface execute_if;
    localparam int unsigned DW = 8;

    // decoder side
    logic          en;
    logic [1:0]    op;
    logic          srcdst;
    logic [DW-1:0] addr;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ready;
    logic          done;
    logic          carry;

    // memory side
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // writeback side
    logic          wb_en;
    logic [1:0]    wb_op;
    logic          wb_srcdst;
    logic [DW-1:0] wb_val;
    logic          wb_ready;

    modport slave (
        input  en, op, srcdst, addr, a, b, mem_rdata, mem_ack, wb_ready,
        output ready, done, carry, mem_rd, mem_wr, mem_addr, mem_wdata,
               wb_en, wb_op, wb_srcdst, wb_val
    );

    modport master (
        output en, op, srcdst, addr, a, b, mem_rdata, mem_ack, wb_ready,
        input  ready, done, carry, mem_rd, mem_wr, mem_addr, mem_wdata,
               wb_en, wb_op, wb_srcdst, wb_val
    );
endinterface

// File: rtl/execute.sv
// Execute stage of the 8-bit core: accepts one decoded instruction at a time
// (NOP/LOD/STO/ADD), runs the memory access if needed and holds the
// writeback request until writeback completes.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : execute_if.slave (decoder, memory and writeback handshakes)
module execute #(
    parameter logic [1:0] OP_NOP = 2'b00,
    parameter logic [1:0] OP_LOD = 2'b01,
    parameter logic [1:0] OP_STO = 2'b10,
    parameter logic [1:0] OP_ADD = 2'b11
) (
    input  logic     clk,
    input  logic     rst_n,
    execute_if.slave bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned SW = DW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_RD,
        S_MEM_WR,
        S_WB,
        S_WB_WAIT
    } state_t;

    state_t        state;
    logic          srcdst_q;
    logic [SW-1:0] sum_c;

    // 9-bit sum so the carry out of the 8-bit add is kept
    assign sum_c = SW'(bus.a) + SW'(bus.b);

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            srcdst_q      <= 1'b0;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.wb_en     <= 1'b0;
            bus.wb_op     <= '0;
            bus.wb_srcdst <= 1'b0;
            bus.wb_val    <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        srcdst_q <= bus.srcdst;
                        if (bus.op == OP_LOD) begin
                            state        <= S_MEM_RD;
                            bus.ready    <= 1'b0;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= bus.addr;
                        end else if (bus.op == OP_STO) begin
                            state         <= S_MEM_WR;
                            bus.ready     <= 1'b0;
                            bus.mem_wr    <= 1'b1;
                            bus.mem_addr  <= bus.addr;
                            bus.mem_wdata <= bus.srcdst ? bus.b : bus.a;
                        end else if (bus.op == OP_ADD) begin
                            state         <= S_WB;
                            bus.ready     <= 1'b0;
                            bus.carry     <= sum_c[DW];
                            bus.wb_val    <= sum_c[DW-1:0];
                            bus.wb_op     <= OP_ADD;
                            bus.wb_srcdst <= bus.srcdst;
                            bus.wb_en     <= 1'b1;
                        end else begin
                            // NOP completes in place
                            bus.done <= 1'b1;
                        end
                    end
                end
                S_MEM_RD: begin
                    if (bus.mem_ack) begin
                        state         <= S_WB;
                        bus.mem_rd    <= 1'b0;
                        bus.wb_val    <= bus.mem_rdata;
                        bus.wb_op     <= OP_LOD;
                        bus.wb_srcdst <= srcdst_q;
                        bus.wb_en     <= 1'b1;
                    end
                end
                S_MEM_WR: begin
                    if (bus.mem_ack) begin
                        state      <= S_IDLE;
                        bus.mem_wr <= 1'b0;
                        bus.ready  <= 1'b1;
                        bus.done   <= 1'b1;
                    end
                end
                S_WB: begin
                    // wb_ready may still be high from the previous instruction
                    state <= S_WB_WAIT;
                end
                S_WB_WAIT: begin
                    if (bus.wb_ready) begin
                        state     <= S_IDLE;
                        bus.wb_en <= 1'b0;
                        bus.ready <= 1'b1;
                        bus.done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: directed cases with literal
// expectations plus randomized instruction streams checked every cycle
// against a transaction-level model of the expected outputs.
module tb_execute;
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] LOD = 2'b01;
    localparam logic [1:0] STO = 2'b10;
    localparam logic [1:0] ADD = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_if bus();

    execute u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // expected outputs
    logic       exp_ready, exp_done, exp_carry, exp_mem_rd, exp_mem_wr;
    logic [7:0] exp_mem_addr, exp_mem_wdata, exp_wb_val;
    logic       exp_wb_en, exp_wb_sd;
    logic [1:0] exp_wb_op;

    int n_chk  = 0;
    int n_pass = 0;

    // observation counters and snapshots taken by the monitor
    int         n_done = 0, n_mem_cyc = 0, n_wb_cyc = 0, n_busy = 0;
    logic [7:0] snap_mem_addr = '0, snap_wdata = '0, snap_wb_val = '0;
    logic [1:0] snap_wb_op = '0;
    logic       snap_wb_sd = 1'b0;

    function automatic logic [32:0] dut_vec();
        return {bus.ready, bus.done, bus.carry, bus.mem_rd, bus.mem_wr,
                bus.mem_addr, bus.mem_wdata, bus.wb_en, bus.wb_op,
                bus.wb_srcdst, bus.wb_val};
    endfunction

    function automatic logic [32:0] exp_vec();
        return {exp_ready, exp_done, exp_carry, exp_mem_rd, exp_mem_wr,
                exp_mem_addr, exp_mem_wdata, exp_wb_en, exp_wb_op,
                exp_wb_sd, exp_wb_val};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic set_exp_reset();
        exp_ready = 1'b1; exp_done = 1'b0; exp_carry = 1'b0;
        exp_mem_rd = 1'b0; exp_mem_wr = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
        exp_wb_en = 1'b0; exp_wb_op = '0; exp_wb_sd = 1'b0; exp_wb_val = '0;
    endtask

    // per-cycle compare and bookkeeping, away from the active edge
    always @(negedge clk) begin
        check("outputs", dut_vec(), exp_vec());
        if (bus.done) n_done++;
        if (!bus.ready) n_busy++;
        if (bus.mem_rd || bus.mem_wr) begin
            n_mem_cyc++;
            snap_mem_addr = bus.mem_addr;
        end
        if (bus.mem_wr) snap_wdata = bus.mem_wdata;
        if (bus.wb_en) begin
            n_wb_cyc++;
            snap_wb_val = bus.wb_val;
            snap_wb_op  = bus.wb_op;
            snap_wb_sd  = bus.wb_srcdst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive inputs the DUT must ignore while busy
    task automatic scramble();
        bus.en     = 1'($urandom_range(0, 1));
        bus.op     = 2'($urandom_range(0, 3));
        bus.srcdst = 1'($urandom_range(0, 1));
        bus.addr   = 8'($urandom);
        bus.a      = 8'($urandom);
        bus.b      = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.en       = 1'b0;
            bus.mem_ack  = 1'($urandom_range(0, 1));
            bus.wb_ready = 1'($urandom_range(0, 1));
            step();
            exp_done = 1'b0;
        end
    endtask

    task automatic mem_phase(input int mem_wait, input logic [7:0] rdata);
        for (int i = 0; i < mem_wait; i++) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 8'($urandom);
            scramble();
            step();
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        step();
    endtask

    // entered with the writeback request just raised
    task automatic wb_phase(input int wb_wait, input bit stale);
        bus.mem_ack  = 1'($urandom_range(0, 1));
        bus.wb_ready = stale ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        for (int i = 0; i < wb_wait; i++) begin
            bus.wb_ready = 1'b0;
            scramble();
            step();
        end
        bus.wb_ready = 1'b1;
        step();
        exp_wb_en = 1'b0;
        exp_ready = 1'b1;
        exp_done  = 1'b1;
    endtask

    // one instruction; returns in the cycle after completion (done cycle)
    task automatic run_instr(input logic [1:0] op, input logic sd, input logic [7:0] addr,
                             input logic [7:0] a, input logic [7:0] b, input logic [7:0] rdata,
                             input int mem_wait, input int wb_wait, input bit stale);
        logic [8:0] sum;
        bus.en       = 1'b1;
        bus.op       = op;
        bus.srcdst   = sd;
        bus.addr     = addr;
        bus.a        = a;
        bus.b        = b;
        bus.mem_ack  = 1'($urandom_range(0, 1));
        bus.wb_ready = stale ? 1'b1 : 1'($urandom_range(0, 1));
        step();
        exp_done  = (op == NOP);
        exp_ready = (op == NOP);
        scramble();
        case (op)
            LOD: begin
                exp_mem_rd   = 1'b1;
                exp_mem_addr = addr;
                mem_phase(mem_wait, rdata);
                exp_mem_rd = 1'b0;
                exp_wb_en  = 1'b1;
                exp_wb_val = rdata;
                exp_wb_op  = LOD;
                exp_wb_sd  = sd;
                wb_phase(wb_wait, stale);
            end
            STO: begin
                exp_mem_wr    = 1'b1;
                exp_mem_addr  = addr;
                exp_mem_wdata = sd ? b : a;
                mem_phase(mem_wait, 8'($urandom));
                exp_mem_wr = 1'b0;
                exp_ready  = 1'b1;
                exp_done   = 1'b1;
                bus.mem_ack = 1'b0;
            end
            ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                exp_carry  = sum[8];
                exp_wb_val = sum[7:0];
                exp_wb_op  = ADD;
                exp_wb_sd  = sd;
                exp_wb_en  = 1'b1;
                wb_phase(wb_wait, stale);
            end
            default: ;
        endcase
        bus.en = 1'b0;
    endtask

    initial begin
        int d0, m0, w0, b0;
        bus.en = 1'b0; bus.op = '0; bus.srcdst = 1'b0; bus.addr = '0;
        bus.a = '0; bus.b = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        bus.wb_ready = 1'b0;
        set_exp_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("reset_state", 33'({bus.ready, bus.done, bus.mem_rd, bus.mem_wr, bus.wb_en}),
              33'(5'b10000));

        // ADD with stale wb_ready, then a back-to-back ADD
        d0 = n_done; w0 = n_wb_cyc;
        run_instr(ADD, 1'b1, 8'h00, 8'hF0, 8'h20, 8'h00, 0, 0, 1'b1);
        check("add_wb_val", 33'(snap_wb_val), 33'(8'h10));
        check("add_carry", 33'(bus.carry), 33'(1'b1));
        check("add_wb_sd", 33'(snap_wb_sd), 33'(1'b1));
        check("add_wb_cycles", 33'(n_wb_cyc - w0), 33'(2));
        run_instr(ADD, 1'b0, 8'h00, 8'h80, 8'h80, 8'h00, 0, 0, 1'b0);
        idle(1);
        check("add2_wb_val", 33'(snap_wb_val), 33'(8'h00));
        check("add2_carry", 33'(bus.carry), 33'(1'b1));
        check("add_b2b_done", 33'(n_done - d0), 33'(2));

        // LOD with two memory wait states
        m0 = n_mem_cyc;
        run_instr(LOD, 1'b0, 8'h3C, 8'h00, 8'h00, 8'hA5, 2, 0, 1'b0);
        check("lod_mem_cycles", 33'(n_mem_cyc - m0), 33'(3));
        check("lod_mem_addr", 33'(snap_mem_addr), 33'(8'h3C));
        check("lod_wb_val", 33'(snap_wb_val), 33'(8'hA5));
        check("lod_wb_op", 33'(snap_wb_op), 33'(2'b01));
        check("lod_wb_sd", 33'(snap_wb_sd), 33'(1'b0));
        idle(1);

        // STO of register b
        m0 = n_mem_cyc; w0 = n_wb_cyc;
        run_instr(STO, 1'b1, 8'h07, 8'h11, 8'h5A, 8'h00, 0, 0, 1'b0);
        check("sto_mem_cycles", 33'(n_mem_cyc - m0), 33'(1));
        check("sto_wdata", 33'(snap_wdata), 33'(8'h5A));
        check("sto_mem_addr", 33'(snap_mem_addr), 33'(8'h07));
        check("sto_no_wb", 33'(n_wb_cyc - w0), 33'(0));
        check("sto_carry_held", 33'(bus.carry), 33'(1'b1));
        idle(1);

        // NOP
        d0 = n_done; m0 = n_mem_cyc; w0 = n_wb_cyc; b0 = n_busy;
        run_instr(NOP, 1'b0, 8'h55, 8'h01, 8'h02, 8'h00, 0, 0, 1'b0);
        idle(1);
        check("nop_done", 33'(n_done - d0), 33'(1));
        check("nop_never_busy", 33'(n_busy - b0), 33'(0));
        check("nop_no_bus", 33'((n_mem_cyc - m0) + (n_wb_cyc - w0)), 33'(0));

        // stray mem_ack and wb_ready while idle
        bus.mem_ack = 1'b1; bus.wb_ready = 1'b1;
        repeat (3) begin step(); exp_done = 1'b0; end
        bus.mem_ack = 1'b0; bus.wb_ready = 1'b0;

        // asynchronous reset in the middle of a LOD
        bus.en = 1'b1; bus.op = LOD; bus.addr = 8'h99;
        step();
        exp_ready = 1'b0; exp_mem_rd = 1'b1; exp_mem_addr = 8'h99;
        bus.en = 1'b0;
        #2;
        rst_n = 1'b0;
        set_exp_reset();
        #1;
        check("async_reset", 33'({bus.mem_rd, bus.wb_en, bus.ready, bus.mem_addr}),
              33'({1'b0, 1'b0, 1'b1, 8'h00}));
        d0 = n_done;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(4);
        check("reset_no_done", 33'(n_done - d0), 33'(0));

        // randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom),
                      8'($urandom), 8'($urandom), 8'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
